decode_regfile: RTL

DECODE_REGFILE -- requirements
Module: decode_regfile

---
 rtl/decode_regfile.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/decode_regfile.sv
// Y86-64 style decode stage with 15-entry register file, write-back and halt tracking.
// Decode IDs and register reads are combinational; writes, state and status flags
// update on the rising clock edge. Reset is synchronous and active-low.
module decode_regfile #(
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] dbg_data,
    output logic        halted,
    output logic        ins_err
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'hE;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [63:0] regs_r [0:14];
    logic        halted_r;
    logic        ins_err_r;
    logic        halt_ins_s;
    logic        bad_ins_s;
    logic        wr_en_s;

    assign halted  = halted_r;
    assign ins_err = ins_err_r;

    // Classify the current instruction as a halting one (halt or unknown code).
    always_comb begin
        bad_ins_s  = (icode > 4'd11);
        halt_ins_s = (icode == 4'd0) || bad_ins_s;
        wr_en_s    = wb_en && (state_r == ST_RUN) && !halt_ins_s;
    end

    // Decode source and destination register IDs from the instruction fields.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            4'd2: begin
                srcA = rA;
                if (cnd) begin
                    dstE = rB;
                end else begin
                    dstE = RNONE;
                end
            end
            4'd3: dstE = rB;
            4'd4: begin
                srcA = rA;
                srcB = rB;
            end
            4'd5: begin
                srcB = rB;
                dstM = rA;
            end
            4'd6: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            4'd8: begin
                srcB = RSP;
                dstE = RSP;
            end
            4'd9: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            4'd10: begin
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            4'd11: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: begin
                srcA = RNONE;
                srcB = RNONE;
                dstE = RNONE;
                dstM = RNONE;
            end
        endcase
    end

    // Read ports: pre-edge register contents, index 15 reads as zero.
    always_comb begin
        if (srcA == RNONE) begin
            valA = 64'h0;
        end else begin
            valA = regs_r[srcA];
        end
        if (srcB == RNONE) begin
            valB = 64'h0;
        end else begin
            valB = regs_r[srcB];
        end
        if (dbg_addr == RNONE) begin
            dbg_data = 64'h0;
        end else begin
            dbg_data = regs_r[dbg_addr];
        end
    end

    // Next-state logic: a committed halting instruction parks the machine until reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (wb_en && halt_ins_s) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // State register and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            halted_r  <= 1'b0;
            ins_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_RUN) && wb_en && halt_ins_s) begin
                halted_r  <= 1'b1;
                ins_err_r <= ins_err_r | bad_ins_s;
            end else begin
                halted_r  <= halted_r;
                ins_err_r <= ins_err_r;
            end
        end
    end

    // Register file write-back; the memory port wins when both target the same register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                if (i == 14) begin
                    regs_r[i] <= RSP_INIT;
                end else begin
                    regs_r[i] <= 64'h0;
                end
            end
        end else if (wr_en_s) begin
            for (int i = 0; i < 15; i++) begin
                if (dstM == 4'(i)) begin
                    regs_r[i] <= valM;
                end else if (dstE == 4'(i)) begin
                    regs_r[i] <= valE;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

endmodule
